// File: rtl/arb_pkg.sv
// Shared constants, state encoding and the rotating-priority search used by rr_arbiter8.
package arb_pkg;

  localparam int unsigned NREQ         = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned HOLD_W       = 8;
  localparam int unsigned HOLD_MAX_DEF = 16;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE  = 1'b0;
  localparam arb_state_t GRANT = 1'b1;

  // First set bit of req scanning ptr+1, ptr+2, ... with wrap; returns ptr when req is empty.
  function automatic logic [IDX_W-1:0] rr_search(input logic [NREQ-1:0] req,
                                                  input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_search = ptr;
    found     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        rr_search = idx;
        found     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/gnt_dec3to8.sv
// Combinational 3-to-8 one-hot decode with enable; the result is registered as gnt.
module gnt_dec3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREQ-1:0]  onehot
);

  // One-hot decode, all zero when disabled
  always_comb begin
    onehot = {NREQ{1'b0}};
    if (en) begin
      case (idx)
        3'd0:    onehot = 8'b0000_0001;
        3'd1:    onehot = 8'b0000_0010;
        3'd2:    onehot = 8'b0000_0100;
        3'd3:    onehot = 8'b0000_1000;
        3'd4:    onehot = 8'b0001_0000;
        3'd5:    onehot = 8'b0010_0000;
        3'd6:    onehot = 8'b0100_0000;
        3'd7:    onehot = 8'b1000_0000;
        default: onehot = {NREQ{1'b0}};
      endcase
    end else begin
      onehot = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered, held grants.
// Optional forced release after HOLD_MAX cycles when built with ARB_HOLD_TIMEOUT_EN.
module rr_arbiter8
  import arb_pkg::*;
`ifdef ARB_HOLD_TIMEOUT_EN
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  arb_state_t       state_r, state_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             valid_r, valid_s;
  logic [NREQ-1:0]  gnt_r, gnt_s;
`ifdef ARB_HOLD_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic [NREQ-1:0]   others_s;
`endif

  // Next-state, grant index, pointer and hold-count selection
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    idx_s   = idx_r;
    valid_s = valid_r;
`ifdef ARB_HOLD_TIMEOUT_EN
    hold_s   = hold_r;
    others_s = req & ~({{(NREQ-1){1'b0}}, 1'b1} << idx_r);
`endif
    case (state_r)
      IDLE: begin
        if (req != {NREQ{1'b0}}) begin
          idx_s   = rr_search(req, ptr_r);
          ptr_s   = rr_search(req, ptr_r);
          valid_s = 1'b1;
          state_s = GRANT;
`ifdef ARB_HOLD_TIMEOUT_EN
          hold_s  = {HOLD_W{1'b0}};
`endif
        end else begin
          valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (req[idx_r]) begin
`ifdef ARB_HOLD_TIMEOUT_EN
          // Grantee overstayed: pass to the next requester, or re-grant with a fresh count
          if (hold_r == HOLD_W'(HOLD_MAX - 1)) begin
            hold_s = {HOLD_W{1'b0}};
            if (others_s != {NREQ{1'b0}}) begin
              idx_s = rr_search(others_s, idx_r);
              ptr_s = rr_search(others_s, idx_r);
            end else begin
              idx_s = idx_r;
            end
          end else if (hold_r != {HOLD_W{1'b1}}) begin
            hold_s = hold_r + 8'd1;
          end else begin
            hold_s = hold_r;
          end
`else
          idx_s = idx_r;
`endif
        end else if (req != {NREQ{1'b0}}) begin
          idx_s  = rr_search(req, idx_r);
          ptr_s  = rr_search(req, idx_r);
`ifdef ARB_HOLD_TIMEOUT_EN
          hold_s = {HOLD_W{1'b0}};
`endif
        end else begin
          valid_s = 1'b0;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  gnt_dec3to8 u_dec (
    .idx    (idx_s),
    .en     (valid_s),
    .onehot (gnt_s)
  );

  // State, pointer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 3'd7;
      idx_r   <= 3'd0;
      valid_r <= 1'b0;
      gnt_r   <= 8'h00;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      idx_r   <= idx_s;
      valid_r <= valid_s;
      gnt_r   <= gnt_s;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  // Consecutive-grant counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= 8'd0;
    end else begin
      hold_r <= hold_s;
    end
  end
`endif

  assign gnt       = gnt_r;
  assign gnt_idx   = idx_r;
  assign gnt_valid = valid_r;

endmodule
